// File: rtl/tl_pkg.sv
// Traffic-light encodings, monitor tracker states and error codes
// shared by the controller and its protocol monitor.
package tl_pkg;

  localparam logic [1:0] RED     = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] GREEN   = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef logic [2:0] mon_state_t;

  localparam mon_state_t SYNC  = 3'd0;
  localparam mon_state_t NSG   = 3'd1;
  localparam mon_state_t NSY   = 3'd2;
  localparam mon_state_t EWG   = 3'd3;
  localparam mon_state_t EWY   = 3'd4;
  localparam mon_state_t EMERG = 3'd5;

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_NONE       = 3'd0;
  localparam err_code_t ERR_ILLEGAL    = 3'd1;
  localparam err_code_t ERR_CONFLICT   = 3'd2;
  localparam err_code_t ERR_BAD_TRANS  = 3'd3;
  localparam err_code_t ERR_EMERG_LATE = 3'd4;
  localparam err_code_t ERR_YELLOW_LEN = 3'd5;
  localparam err_code_t ERR_GREEN_LEN  = 3'd6;

  // Phase implied by a legal, non-conflicting light pair.
  function automatic mon_state_t phase_of(
    input logic [1:0] ns,
    input logic [1:0] ew
  );
    phase_of = SYNC;
    if (ns == GREEN && ew == RED)
      phase_of = NSG;
    else if (ns == YELLOW && ew == RED)
      phase_of = NSY;
    else if (ns == RED && ew == GREEN)
      phase_of = EWG;
    else if (ns == RED && ew == YELLOW)
      phase_of = EWY;
    else if (ns == RED && ew == RED)
      phase_of = EMERG;
  endfunction

  function automatic mon_state_t next_of(input mon_state_t s);
    case (s)
      NSG:     next_of = NSY;
      NSY:     next_of = EWG;
      EWG:     next_of = EWY;
      EWY:     next_of = NSG;
      EMERG:   next_of = NSG;
      default: next_of = SYNC;
    endcase
  endfunction

endpackage

// File: rtl/tlm_phase_timer.sv
// Saturating phase-duration counter; reloads to 1 on a state change
// and flags when the duration equals or exceeds a target length.
module tlm_phase_timer #(
  parameter int LEN   = 8,
  parameter int DUR_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reload,
  output logic eq_len,
  output logic over_len
);

  logic [DUR_W-1:0] dur;

  always_ff @(posedge clk) begin
    if (!reset_n)
      dur <= '0;
    else if (reload)
      dur <= DUR_W'(1);
    else if (dur != '1)
      dur <= dur + DUR_W'(1);
  end

  assign eq_len   = (dur == DUR_W'(LEN));
  assign over_len = (dur > DUR_W'(LEN));

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light output bus.
// Optional statistics counters: define TLM_STATS_EN.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int EMERG_LAT     = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       ns_light,
  input  logic [1:0]       ew_light,
  input  logic             emergency,
  input  logic             clr_err,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic             err_sticky,
  output logic [2:0]       mon_state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] emerg_cnt
);

  localparam int DUR_W = $clog2(GREEN_CYCLES + YELLOW_CYCLES + 2) + 1;
  localparam int LAT_W = $clog2(EMERG_LAT + 2);

  mon_state_t st, st_n, obs;
  err_code_t  code;

  logic illegal, conflict, both_red;
  logic is_grn, is_yel, reload;
  logic g_eq, g_over, y_eq, y_over;
  logic bad, len5, len6, emerg_ok;

  logic [EMERG_LAT-1:0] hist;
  logic [EMERG_LAT:0]   hist_n;

  logic             pend, pend_n, done, done_n, late;
  logic [LAT_W-1:0] lat, lat_n;

  assign illegal  = (ns_light == ILLEGAL) || (ew_light == ILLEGAL);
  assign conflict = (ns_light != RED) && (ew_light != RED);
  assign both_red = (ns_light == RED) && (ew_light == RED);
  assign obs      = phase_of(ns_light, ew_light);
  assign is_grn   = (st == NSG) || (st == EWG);
  assign is_yel   = (st == NSY) || (st == EWY);
  assign reload   = (st_n != st);

  // Current sample plus the previous EMERG_LAT samples.
  assign hist_n   = {hist, emergency};
  assign emerg_ok = |hist_n;

  tlm_phase_timer #(.LEN(GREEN_CYCLES), .DUR_W(DUR_W)) u_grn (
    .clk      (clk),
    .reset_n  (reset_n),
    .reload   (reload),
    .eq_len   (g_eq),
    .over_len (g_over)
  );

  tlm_phase_timer #(.LEN(YELLOW_CYCLES), .DUR_W(DUR_W)) u_yel (
    .clk      (clk),
    .reset_n  (reset_n),
    .reload   (reload),
    .eq_len   (y_eq),
    .over_len (y_over)
  );

  // One request stays open until both lights go red; late reported once.
  always_comb begin
    pend_n = pend;
    done_n = done;
    lat_n  = lat;
    late   = 1'b0;
    if (st == SYNC || both_red) begin
      pend_n = 1'b0;
      done_n = 1'b0;
      lat_n  = '0;
    end else if (!pend) begin
      if (emergency) begin
        pend_n = 1'b1;
        done_n = 1'b0;
        lat_n  = '0;
      end
    end else if (!done) begin
      lat_n = lat + LAT_W'(1);
      if (lat == LAT_W'(EMERG_LAT - 1)) begin
        late   = 1'b1;
        done_n = 1'b1;
      end
    end else if (!emergency) begin
      pend_n = 1'b0;
    end
  end

  always_comb begin
    st_n = st;
    code = ERR_NONE;
    bad  = 1'b0;
    len5 = 1'b0;
    len6 = 1'b0;
    if (illegal) begin
      code = ERR_ILLEGAL;
      st_n = SYNC;
    end else if (conflict) begin
      code = ERR_CONFLICT;
      st_n = SYNC;
    end else if (st == SYNC) begin
      if (obs == NSG)
        st_n = NSG;
    end else begin
      if (obs == st) begin
        len5 = is_yel && y_eq;
        len6 = is_grn && g_eq;
      end else if (obs == EMERG) begin
        if (emerg_ok)
          st_n = EMERG;
        else
          bad = 1'b1;
      end else if (obs == next_of(st)) begin
        if (st == EMERG && emergency) begin
          bad = 1'b1;
        end else begin
          st_n = obs;
          len5 = is_yel && !y_eq && !y_over;
          len6 = is_grn && !g_eq && !g_over;
        end
      end else begin
        bad = 1'b1;
      end
      if (bad) begin
        code = ERR_BAD_TRANS;
        st_n = SYNC;
      end else if (late) begin
        code = ERR_EMERG_LATE;
      end else if (len5) begin
        code = ERR_YELLOW_LEN;
      end else if (len6) begin
        code = ERR_GREEN_LEN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st         <= SYNC;
      hist       <= '0;
      pend       <= 1'b0;
      done       <= 1'b0;
      lat        <= '0;
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      err_sticky <= 1'b0;
    end else begin
      st         <= st_n;
      hist       <= hist_n[EMERG_LAT-1:0];
      pend       <= pend_n;
      done       <= done_n;
      lat        <= lat_n;
      err_valid  <= (code != ERR_NONE);
      err_code   <= code;
      err_sticky <= (code != ERR_NONE) || (err_sticky && !clr_err);
    end
  end

  assign mon_state = st;

`ifdef TLM_STATS_EN
  logic [CNT_W-1:0] cyc_q, emg_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cyc_q <= '0;
      emg_q <= '0;
    end else begin
      if (st == EWY && st_n == NSG)
        cyc_q <= cyc_q + CNT_W'(1);
      if (st != EMERG && st_n == EMERG)
        emg_q <= emg_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign emerg_cnt = emg_q;
`else
  assign cycle_cnt = '0;
  assign emerg_cnt = '0;
`endif

endmodule
